// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, imem req/gnt/rvalid, skid buffer, IF/ID slot
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  input  logic        id_ready,
  output logic        fetch_misalign
);

  typedef enum logic [2:0] {S_FETCH, S_WAIT, S_HOLD, S_DISCARD, S_ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic [31:0] slot_instr_q, slot_instr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        slot_free;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    slot_free    = !valid_q || id_ready;

    if (valid_q && id_ready) valid_d = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (req_q && imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          pc_d = pc_q + 32'd4;
          if (slot_free) begin
            valid_d      = 1'b1;
            slot_pc_d    = pc_q;
            slot_instr_d = imem_rdata;
            state_d      = S_FETCH;
          end else begin
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_q;
            skid_instr_d = imem_rdata;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (id_ready) begin
          valid_d      = 1'b1;
          slot_pc_d    = skid_pc_q;
          slot_instr_d = skid_instr_q;
          skid_valid_d = 1'b0;
          state_d      = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (imem_rvalid) state_d = S_FETCH;
      end
      default: state_d = S_ERR;
    endcase

    // A granted request whose response has not yet arrived must be drained in DISCARD.
    if (redirect_valid) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
      pc_d         = redirect_pc;
      if ((state_q == S_WAIT && !imem_rvalid) ||
          (state_q == S_FETCH && req_q && imem_gnt) ||
          (state_q == S_DISCARD && !imem_rvalid))
        state_d = S_DISCARD;
      else
        state_d = S_FETCH;
    end

    if (state_d == S_FETCH && pc_d[1:0] != 2'b00) state_d = S_ERR;

    req_d = (state_d == S_FETCH) && !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      slot_pc_q    <= 32'h0;
      slot_instr_q <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = pc_q;
  assign pc_out         = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_pc       = slot_pc_q;
  assign if_id_instr    = slot_instr_q;
  assign fetch_misalign = (state_q == S_ERR);

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed and randomized checks of if_fetch_unit against a stream model
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_out;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        id_ready = 1'b0;
  logic        fetch_misalign;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc_out(pc_out),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .id_ready(id_ready), .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 8) begin
      tick();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL wait_req: imem_req=%b after %0d cycles, required 1", imem_req, n);
    end
  endtask

  task automatic fetch_one(input logic [31:0] data);
    wait_req();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = data;
    tick();
    imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (pc_out !== 32'h3000 || if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_instr !== 32'h0 ||
        imem_req !== 1'b0 || fetch_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%h v=%b ipc=%h instr=%h req=%b mis=%b, required 3000 0 0 0 0 0",
               pc_out, if_id_valid, if_id_pc, if_id_instr, imem_req, fetch_misalign);
    end
  endtask

  task automatic test_basic();
    wait_req();
    checks++;
    if (imem_addr !== 32'h3000) begin
      errors++;
      $display("FAIL basic_addr: addr=%h required 00003000", imem_addr);
    end
    id_ready = 1'b1;
    fetch_one(32'h2408_0005);
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h3000 || if_id_instr !== 32'h2408_0005 ||
        imem_req !== 1'b1 || imem_addr !== 32'h3004) begin
      errors++;
      $display("FAIL basic_slot: v=%b pc=%h instr=%h req=%b addr=%h, required 1 3000 24080005 1 3004",
               if_id_valid, if_id_pc, if_id_instr, imem_req, imem_addr);
    end
    id_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    fetch_one(32'hAAAA_0001);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b0 || if_id_valid !== 1'b1 || if_id_pc !== 32'h3000 ||
          if_id_instr !== 32'h2408_0005 || pc_out !== 32'h3008) begin
        errors++;
        $display("FAIL stall_%0d: req=%b v=%b pc=%h instr=%h pcout=%h, required 0 1 3000 24080005 3008",
                 i, imem_req, if_id_valid, if_id_pc, if_id_instr, pc_out);
      end
      tick();
    end
    id_ready = 1'b1;
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h3004 || if_id_instr !== 32'hAAAA_0001 ||
        imem_req !== 1'b1 || imem_addr !== 32'h3008) begin
      errors++;
      $display("FAIL release_skid: v=%b pc=%h instr=%h req=%b addr=%h, required 1 3004 aaaa0001 1 3008",
               if_id_valid, if_id_pc, if_id_instr, imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    checks++;
    if (if_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_clear: v=%b required 0", if_id_valid);
    end
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBBBB_0002;
    tick();
    imem_rvalid = 1'b0;
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h3008 || if_id_instr !== 32'hBBBB_0002) begin
      errors++;
      $display("FAIL release_next: v=%b pc=%h instr=%h, required 1 3008 bbbb0002",
               if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_redirect_wait();
    wait_req();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (if_id_valid !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL discard_%0d: v=%b req=%b, required 0 0", i, if_id_valid, imem_req);
      end
      tick();
    end
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    checks++;
    if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3100) begin
      errors++;
      $display("FAIL discard_done: v=%b req=%b addr=%h, required 0 1 3100", if_id_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_same_cycle();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1111_2222;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3300;
    tick();
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3300) begin
      errors++;
      $display("FAIL redir_rvalid: v=%b req=%b addr=%h, required 0 1 3300", if_id_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1;
    redirect_pc = 32'h3102;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fetch_misalign !== 1'b1 || imem_req !== 1'b0 || pc_out !== 32'h3102) begin
        errors++;
        $display("FAIL misalign_%0d: mis=%b req=%b pc=%h, required 1 0 3102", i, fetch_misalign, imem_req, pc_out);
      end
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h3200;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fetch_misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3200) begin
      errors++;
      $display("FAIL misalign_exit: mis=%b req=%b addr=%h, required 0 1 3200", fetch_misalign, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap_and_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    fetch_one(32'h0C0C_0C0C);
    checks++;
    if (if_id_pc !== 32'hFFFF_FFFC || if_id_instr !== 32'h0C0C_0C0C || imem_req !== 1'b1 ||
        imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap: pc=%h instr=%h req=%b addr=%h, required fffffffc 0c0c0c0c 1 0",
               if_id_pc, if_id_instr, imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (pc_out !== 32'h3000 || if_id_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait: pc=%h v=%b req=%b, required 3000 0 0", pc_out, if_id_valid, imem_req);
    end
    imem_rvalid = 1'b1;
    imem_rdata = 32'h5555_5555;
    tick();
    imem_rvalid = 1'b0;
    checks++;
    if (if_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL late_rvalid: v=%b required 0", if_id_valid);
    end
    wait_req();
    checks++;
    if (imem_addr !== 32'h3000) begin
      errors++;
      $display("FAIL rst_resume: addr=%h required 00003000", imem_addr);
    end
    id_ready = 1'b0;
  endtask

  // Model: the consumed stream must run target, target+4, ... between redirects, each word = mem_word(pc).
  task automatic test_random();
    logic [31:0] exp_pc = 32'h3000;
    logic        outst = 1'b0;
    logic [31:0] oaddr = 32'h0;
    int          cnt = 0;
    int          consumed = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    logic [31:0] tgt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (prev_hold) begin
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== prev_pc || if_id_instr !== prev_instr) begin
          errors++;
          $display("FAIL rnd_stable c=%0d: v=%b pc=%h instr=%h, required 1 %h %h",
                   c, if_id_valid, if_id_pc, if_id_instr, prev_pc, prev_instr);
        end
      end
      imem_rvalid = 1'b0;
      if (outst) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = mem_word(oaddr);
        end else begin
          cnt--;
        end
      end
      imem_gnt = imem_req && ($urandom_range(0, 1) == 1);
      id_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      tgt = {16'h0000, 14'($urandom), 2'b00};
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      redirect_pc = tgt;

      if (if_id_valid && id_ready) begin
        checks++;
        if (if_id_pc !== exp_pc || if_id_instr !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL rnd_stream c=%0d: pc=%h instr=%h, required %h %h",
                   c, if_id_pc, if_id_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      if (imem_rvalid) outst = 1'b0;
      if (imem_gnt) begin
        checks++;
        if (outst) begin
          errors++;
          $display("FAIL rnd_outstanding c=%0d: second grant at %h while %h pending", c, imem_addr, oaddr);
        end
        outst = 1'b1;
        oaddr = imem_addr;
        cnt = $urandom_range(0, 2);
      end
      prev_hold = if_id_valid && !id_ready && !redirect_valid;
      prev_pc = if_id_pc;
      prev_instr = if_id_instr;
      tick();
    end
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    checks++;
    if (consumed < 100) begin
      errors++;
      $display("FAIL rnd_progress: consumed=%0d required >=100", consumed);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_misalign();
    test_wrap_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
